// File: rtl/alarma_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alarma_ctrl                                                            |
// | Intrusion-alarm panel controller: exit/entry delays, siren timing and  |
// | alarm memory, all timed by one shared 16-bit down-counter.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module alarma_ctrl #(
    parameter int unsigned EXIT_CYC  = 16,
    parameter int unsigned ENTRY_CYC = 16,
    parameter int unsigned SIREN_CYC = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic       P,
    input  logic       Co,
    input  logic       Ca,
    input  logic       G,
    input  logic       V,
    input  logic       Pa,
    output logic       Bocina,
    output logic       armed,
    output logic       beep,
    output logic [2:0] state,
    output logic [5:0] zone_mem
);

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_ENTRY    = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    // Loading N-1 and expiring at zero yields exactly N cycles in the state.
    localparam logic [15:0] C_EXIT_LOAD  = 16'(EXIT_CYC  - 1);
    localparam logic [15:0] C_ENTRY_LOAD = 16'(ENTRY_CYC - 1);
    localparam logic [15:0] C_SIREN_LOAD = 16'(SIREN_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic [5:0]  zone_q, zone_d;

    logic        w_expired;
    logic        w_instant;
    logic [5:0]  w_sample;

    assign w_expired = (cnt_q == 16'd0);
    assign w_instant = Co | Ca | G | V;
    assign w_sample  = {Pa, V, G, Ca, Co, P};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DISARMED;
            cnt_q   <= 16'd0;
            armed_q <= 1'b0;
            zone_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            zone_q  <= zone_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = w_expired ? 16'd0 : cnt_q - 16'd1;
        armed_d = armed_q;
        zone_d  = zone_q;

        if (Pa && (state_q <= S_ALARM)) begin
            // Panic wins everywhere; in ALARM it restarts the siren period.
            state_d = S_ALARM;
            cnt_d   = C_SIREN_LOAD;
            zone_d  = zone_q | w_sample;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    armed_d = 1'b0;
                    if (arm) begin
                        state_d = S_EXIT;
                        cnt_d   = C_EXIT_LOAD;
                        zone_d  = 6'd0;
                    end
                end
                S_EXIT: begin
                    if (disarm) begin
                        state_d = S_DISARMED;
                        armed_d = 1'b0;
                    end else if (w_expired) begin
                        state_d = S_ARMED;
                        armed_d = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_instant) begin
                        state_d = S_ALARM;
                        cnt_d   = C_SIREN_LOAD;
                        zone_d  = zone_q | w_sample;
                    end else if (disarm) begin
                        state_d = S_DISARMED;
                        armed_d = 1'b0;
                    end else if (P) begin
                        state_d = S_ENTRY;
                        cnt_d   = C_ENTRY_LOAD;
                    end
                end
                S_ENTRY: begin
                    if (w_instant) begin
                        state_d = S_ALARM;
                        cnt_d   = C_SIREN_LOAD;
                        zone_d  = zone_q | w_sample;
                    end else if (disarm) begin
                        state_d = S_DISARMED;
                        armed_d = 1'b0;
                    end else if (w_expired) begin
                        // Entry delay ran out: blame the door zone.
                        state_d = S_ALARM;
                        cnt_d   = C_SIREN_LOAD;
                        zone_d  = zone_q | w_sample | 6'b000001;
                    end
                end
                S_ALARM: begin
                    if (disarm) begin
                        state_d = S_DISARMED;
                        armed_d = 1'b0;
                    end else if (w_expired) begin
                        state_d = armed_q ? S_ARMED : S_DISARMED;
                    end
                end
                default: begin
                    state_d = S_DISARMED;
                    cnt_d   = 16'd0;
                    armed_d = 1'b0;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        Bocina   = (state_q == S_ALARM);
        beep     = (state_q == S_EXIT) || (state_q == S_ENTRY);
        armed    = armed_q;
        state    = state_q;
        zone_mem = zone_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alarma_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_alarma_ctrl                                                         |
// | Directed self-checking bench for alarma_ctrl (EXIT=4, ENTRY=3, SIREN=5)|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_alarma_ctrl;

    logic       clk;
    logic       rst_n;
    logic       arm, disarm, P, Co, Ca, G, V, Pa;
    logic       Bocina, armed, beep;
    logic [2:0] state;
    logic [5:0] zone_mem;

    int total_cnt;
    int bad_cnt;

    alarma_ctrl #(
        .EXIT_CYC  (4),
        .ENTRY_CYC (3),
        .SIREN_CYC (5)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .disarm   (disarm),
        .P        (P),
        .Co       (Co),
        .Ca       (Ca),
        .G        (G),
        .V        (V),
        .Pa       (Pa),
        .Bocina   (Bocina),
        .armed    (armed),
        .beep     (beep),
        .state    (state),
        .zone_mem (zone_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("exit_beep", 32'(beep), 32'd1);
            chk("exit_state", 32'(state), 32'd1);
            tick();
        end
        chk("armed_state", 32'(state), 32'd2);
        chk("armed_flag", 32'(armed), 32'd1);
        chk("armed_beep", 32'(beep), 32'd0);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n = 1'b0;
        {arm, disarm, P, Co, Ca, G, V, Pa} = '0;
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_bocina", 32'(Bocina), 32'd0);
        chk("rst_beep", 32'(beep), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_zone", 32'(zone_mem), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // arm -> 4 cycles of exit beep -> ARMED
        do_arm();

        // door opens, nobody disarms: entry then siren, memory shows door
        P = 1'b1;
        tick();
        P = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("entry_beep", 32'(beep), 32'd1);
            chk("entry_state", 32'(state), 32'd3);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("siren_on", 32'(Bocina), 32'd1);
            tick();
        end
        chk("siren_ret_state", 32'(state), 32'd2);
        chk("siren_off", 32'(Bocina), 32'd0);
        chk("door_zone", 32'(zone_mem), 32'h01);
        chk("siren_ret_armed", 32'(armed), 32'd1);

        // door opens, disarm on second entry cycle
        P = 1'b1;
        tick();
        P = 1'b0;
        chk("entry1_bocina", 32'(Bocina), 32'd0);
        tick();
        chk("entry2_state", 32'(state), 32'd3);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("disarm_state", 32'(state), 32'd0);
        chk("disarm_armed", 32'(armed), 32'd0);
        chk("disarm_bocina", 32'(Bocina), 32'd0);
        chk("zone_persist", 32'(zone_mem), 32'h01);

        // clean slate, then panic while disarmed
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        Pa = 1'b1;
        tick();
        Pa = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("panic_siren", 32'(Bocina), 32'd1);
            tick();
        end
        chk("panic_ret_state", 32'(state), 32'd0);
        chk("panic_ret_armed", 32'(armed), 32'd0);
        chk("panic_zone", 32'(zone_mem), 32'h20);

        // arm clears memory; arm while armed is ignored
        do_arm();
        chk("arm_clears_zone", 32'(zone_mem), 32'h00);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_ignored", 32'(state), 32'd2);

        // instant zone beats a simultaneous disarm
        G = 1'b1;
        disarm = 1'b1;
        tick();
        G = 1'b0;
        disarm = 1'b0;
        chk("g_alarm_state", 32'(state), 32'd4);
        chk("g_zone", 32'(zone_mem), 32'h08);
        tick();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("g_disarm_state", 32'(state), 32'd0);
        chk("g_zone_held", 32'(zone_mem), 32'h08);
        chk("g_disarm_armed", 32'(armed), 32'd0);

        // siren expires back to ARMED with V still open -> re-alarm
        do_arm();
        V = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("v_alarm", 32'(state), 32'd4);
        end
        tick();
        chk("v_return_armed", 32'(state), 32'd2);
        tick();
        chk("v_realarm", 32'(state), 32'd4);
        chk("v_zone", 32'(zone_mem), 32'h10);
        V = 1'b0;

        // async reset between edges while in ALARM
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_bocina", 32'(Bocina), 32'd0);
        chk("async_zone", 32'(zone_mem), 32'd0);
        chk("async_armed", 32'(armed), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_bocina", 32'(Bocina), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarma_ctrl.md
ALARMA_CTRL -- requirements
Module: alarma_ctrl

Interface
REQ-001 Parameter EXIT_CYC, 16, exit-delay length in clock cycles (1..65535).
REQ-002 Parameter ENTRY_CYC, 16, entry-delay length in clock cycles (1..65535).
REQ-003 Parameter SIREN_CYC, 32, siren-on length in clock cycles (1..65535).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 arm  input  1  arm request, sampled each edge.
REQ-007 disarm  input  1  valid-code disarm request, sampled each edge.
REQ-008 P  input  1  door sensor (delayed zone).
REQ-009 Co, Ca, G, V  input  1 each  instant zones.
REQ-010 Pa  input  1  panic button, active in every state.
REQ-011 Bocina  output  1  siren drive.
REQ-012 armed  output  1  system-armed indicator.
REQ-013 beep  output  1  keypad beeper, exit/entry warning.
REQ-014 state  output  3  current state code.
REQ-015 zone_mem  output  6  alarm memory {Pa,V,G,Ca,Co,P}.

Function
REQ-016 States SHALL be DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 SHALL return to DISARMED on next edge.
REQ-017 One 16-bit down-counter SHALL time all delays; loaded with N-1 on state entry, decremented each cycle, expiry when 0, giving exactly N cycles in the state.
REQ-018 Pa=1 in any state SHALL transition to ALARM next edge; highest priority.
REQ-019 DISARMED: arm=1 -> EXIT, load EXIT_CYC-1, clear zone_mem; sensors other than Pa ignored; disarm ignored.
REQ-020 EXIT: disarm=1 -> DISARMED; else expiry -> ARMED and set armed flag; sensors other than Pa ignored.
REQ-021 ARMED: priority Co|Ca|G|V -> ALARM, then disarm -> DISARMED, then P -> ENTRY (load ENTRY_CYC-1).
REQ-022 ENTRY: priority Co|Ca|G|V -> ALARM, then disarm -> DISARMED, then expiry -> ALARM; P ignored.
REQ-023 ALARM entry SHALL load SIREN_CYC-1; Pa=1 while in ALARM SHALL reload it.
REQ-024 ALARM: disarm=1 (with Pa=0) -> DISARMED; expiry -> ARMED if armed flag set, else DISARMED.
REQ-025 Return from ALARM to ARMED with an instant zone still active SHALL re-enter ALARM next edge.
REQ-026 On each transition into ALARM, zone_mem SHALL OR in the sampled {Pa,V,G,Ca,Co,P}; entry-delay expiry SHALL set bit 0 (P).
REQ-027 zone_mem SHALL persist through disarm and clear only on arm acceptance or reset.
REQ-028 armed flag SHALL clear on any transition to DISARMED.
REQ-029 arm in any state other than DISARMED SHALL be ignored.
REQ-030 Outputs SHALL be registered/Moore: Bocina=(state==ALARM), beep=(state==EXIT|ENTRY), armed=flag; no combinational input-to-output path; response visible one edge after sampling.

Reset
REQ-031 rst_n=0 SHALL immediately, without clock, force state=DISARMED, counter=0, armed=0, zone_mem=0, Bocina=0, beep=0.
REQ-032 Reset asserted mid-delay or mid-alarm SHALL abort with no residual timing; first edge after release evaluates from DISARMED.

Verification (EXIT_CYC=4, ENTRY_CYC=3, SIREN_CYC=5)
REQ-033 arm pulse -> beep=1 for exactly 4 cycles, then state=2, armed=1, beep=0.
REQ-034 ARMED, P pulse, no disarm -> beep 3 cycles, Bocina=1 for 5 cycles, zone_mem=6'b000001, return to state=2.
REQ-035 ARMED, P pulse, disarm on 2nd entry cycle -> state=0, Bocina never 1, armed=0.
REQ-036 DISARMED, Pa=1 one cycle -> Bocina=1 5 cycles, zone_mem=6'b100000, return to state=0 with armed=0.
REQ-037 ARMED, G=1 and disarm=1 same edge -> state=4, zone_mem bit 3 set; then disarm -> state=0, zone_mem held until next arm.
REQ-038 rst_n low during ALARM between edges -> Bocina=0 and state=0 before next clock edge.
